shift_op_controller: RTL

//  Sequences the x2/x4 and /2 /4 shift datapath from one-hot operation requests.

---
 rtl/shift_op_controller_pkg.sv | 34 +++
 rtl/shift_op_controller_univ_shift_reg.sv | 28 ++
 rtl/shift_op_controller.sv | 111 +++++++++++
 3 files changed

// File: rtl/shift_op_controller_pkg.sv
// Shared op codes, FSM states and shift-register controls
// for the x2/x4 and /2 /4 shift sequencer.
package shift_op_controller_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [1:0] OP_X2   = 2'd0;
    localparam logic [1:0] OP_X4   = 2'd1;
    localparam logic [1:0] OP_DIV2 = 2'd2;
    localparam logic [1:0] OP_DIV4 = 2'd3;

    localparam logic [1:0] CNT_1 = 2'd1;
    localparam logic [1:0] CNT_2 = 2'd2;

    localparam logic [1:0] SR_HOLD = 2'b00;
    localparam logic [1:0] SR_SHL  = 2'b01;
    localparam logic [1:0] SR_SHR  = 2'b10;
    localparam logic [1:0] SR_LOAD = 2'b11;

    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    function automatic logic [1:0] op_shift_cnt(input logic [1:0] op);
        return (op == OP_X4 || op == OP_DIV4) ? CNT_2 : CNT_1;
    endfunction

endpackage

// File: rtl/shift_op_controller_univ_shift_reg.sv
// Universal shift register: hold, shift left/right with
// zero serial-in, or parallel load.
module univ_shift_reg
    import shift_op_controller_pkg::*;
#(
    parameter int W = 10
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic [1:0]   ctrl,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            q <= '0;
        end else begin
            unique case (ctrl)
                SR_SHL:  q <= {q[W-2:0], 1'b0};
                SR_SHR:  q <= {1'b0, q[W-1:1]};
                SR_LOAD: q <= d;
                default: q <= q;
            endcase
        end
    end

endmodule

// File: rtl/shift_op_controller.sv
// Edge-triggered one-hot op sequencer driving a shift register;
// publishes a held, registered result with a one-cycle valid pulse.
module shift_op_controller
    import shift_op_controller_pkg::*;
#(
    parameter int OP_W  = 8,
    parameter int RES_W = 10
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [OP_W-1:0]  OPERAND,
    input  logic [3:0]       REQ,
    output logic [RES_W-1:0] RESULT,
    output logic             RESULT_VALID,
    output logic [1:0]       OP_DONE,
    output logic             BUSY,
    output logic             ERR
);

    state_t           state, state_n;
    logic [3:0]       req_d;
    logic [3:0]       req_new;
    logic [1:0]       op_q, req_op;
    logic [1:0]       cnt_q;
    logic [1:0]       sr_ctrl;
    logic [RES_W-1:0] sr_d, sr_q;

    assign req_new = REQ & ~req_d;
    assign sr_d    = {{(RES_W-OP_W){1'b0}}, OPERAND};

    always_comb begin
        req_op = OP_X2;
        if (is_onehot4(REQ)) begin
            unique case (1'b1)
                REQ[0]: req_op = OP_X2;
                REQ[1]: req_op = OP_X4;
                REQ[2]: req_op = OP_DIV2;
                REQ[3]: req_op = OP_DIV4;
                default: req_op = OP_X2;
            endcase
        end
    end

    always_comb begin
        state_n = state;
        sr_ctrl = SR_HOLD;
        unique case (state)
            S_IDLE: begin
                if (req_new != 4'd0)
                    state_n = is_onehot4(REQ) ? S_LOAD : S_ERROR;
            end
            S_LOAD: begin
                sr_ctrl = SR_LOAD;
                state_n = S_SHIFT;
            end
            S_SHIFT: begin
                sr_ctrl = op_q[1] ? SR_SHR : SR_SHL;
                if (cnt_q == CNT_1)
                    state_n = S_DONE;
            end
            S_DONE:  state_n = S_IDLE;
            S_ERROR: begin
                if (REQ == 4'd0)
                    state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // req_d updates in every state so held buttons never retrigger
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state        <= S_IDLE;
            req_d        <= 4'hF;
            op_q         <= OP_X2;
            cnt_q        <= 2'd0;
            RESULT       <= '0;
            RESULT_VALID <= 1'b0;
            OP_DONE      <= 2'd0;
            BUSY         <= 1'b0;
            ERR          <= 1'b0;
        end else begin
            state        <= state_n;
            req_d        <= REQ;
            RESULT_VALID <= (state == S_DONE);
            BUSY         <= (state_n == S_LOAD)
                         || (state_n == S_SHIFT)
                         || (state_n == S_DONE);
            ERR          <= (state_n == S_ERROR);
            if (state == S_IDLE && state_n == S_LOAD) begin
                op_q  <= req_op;
                cnt_q <= op_shift_cnt(req_op);
            end
            if (state == S_SHIFT)
                cnt_q <= cnt_q - 2'd1;
            if (state == S_DONE) begin
                RESULT  <= sr_q;
                OP_DONE <= op_q;
            end
        end
    end

    univ_shift_reg #(.W(RES_W)) u_sr (
        .CLK   (CLK),
        .RST_N (RST_N),
        .ctrl  (sr_ctrl),
        .d     (sr_d),
        .q     (sr_q)
    );

endmodule
